// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - load/store data-port responder with byte-lane RAM and fixed access latency
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  len_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] off_d;
    logic [AW-1:0] idx_d;
    logic [4:0]  sh_d;
    logic [3:0]  lanes_d;
    logic [31:0] len_mask_d;
    logic [31:0] word_d;
    logic [31:0] wdata_sh_d;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        do_access_d;

    // Access decode works from the latched request, so inputs need not be held.
    always_comb begin
        off_d      = addr_q - BASE_ADDR;
        idx_d      = off_d[AW+1:2];
        sh_d       = {addr_q[1:0], 3'b000};
        word_d     = mem_q[idx_d];
        wdata_sh_d = wdata_q << sh_d;
        lanes_d    = 4'b0000;
        len_mask_d = 32'h0000_0000;
        case (len_q)
            3'd1: begin
                lanes_d    = 4'b0001 << addr_q[1:0];
                len_mask_d = 32'h0000_00FF;
            end
            3'd2: begin
                lanes_d    = 4'b0011 << addr_q[1:0];
                len_mask_d = 32'h0000_FFFF;
            end
            3'd4: begin
                lanes_d    = 4'b1111;
                len_mask_d = 32'hFFFF_FFFF;
            end
            default: begin
                lanes_d    = 4'b0000;
                len_mask_d = 32'h0000_0000;
            end
        endcase
        err_d = (addr_q < BASE_ADDR) || (off_d >= SPAN)
             || !(len_q inside {3'd1, 3'd2, 3'd4})
             || ((len_q == 3'd2) && addr_q[0])
             || ((len_q == 3'd4) && (addr_q[1:0] != 2'b00));
        rdata_d     = (err_d || wen_q) ? 32'h0 : ((word_d >> sh_d) & len_mask_d);
        do_access_d = (state_q == S_WAIT) && (cnt_q == 4'd0);
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        len_q   <= req_len;
                        cnt_q   <= 4'(LATENCY);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM is never cleared; a reset before the access cycle suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && do_access_d && wen_q && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_d[b]) begin
                    mem_q[idx_d][8*b +: 8] <= wdata_sh_d[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_wen;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [2:0]  z_req_len;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wen(z_req_wen),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_len(z_req_len),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] len, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int  n;
        logic acc;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_len = len;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        check("accept", {31'b0, acc}, 32'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
        lat = n; rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] len,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(wen, addr, wdata, len, 0, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, "_lat"}, 32'(lat), 32'd3);
    endtask

    task automatic xact0(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
        int n;
        z_req_valid = 1'b1; z_req_wen = wen; z_req_addr = addr; z_req_wdata = wdata; z_req_len = 3'd4;
        n = 0;
        while (!z_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        n = 0;
        while (!z_rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd1);
        check({tag, "_rdata"}, z_rsp_rdata, exp_rd);
        z_rsp_ready = 1'b1;
        @(posedge clk); #1;
        z_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, seen;
        int          lat;

        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_len = 3'd4;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_len = 3'd4;
        z_rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        run("sw_10", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd4, 32'h0, 1'b0);
        run("lw_10", 1'b0, 32'h8000_0010, 32'h0, 3'd4, 32'hDEAD_BEEF, 1'b0);

        run("sw_base", 1'b1, 32'h8000_0010, 32'h1122_3344, 3'd4, 32'h0, 1'b0);
        run("sb_13", 1'b1, 32'h8000_0013, 32'h0000_005A, 3'd1, 32'h0, 1'b0);
        run("lw_sb", 1'b0, 32'h8000_0010, 32'h0, 3'd4, 32'h5A22_3344, 1'b0);
        run("lb_13", 1'b0, 32'h8000_0013, 32'h0, 3'd1, 32'h0000_005A, 1'b0);
        run("lb_10", 1'b0, 32'h8000_0010, 32'h0, 3'd1, 32'h0000_0044, 1'b0);
        run("lh_12", 1'b0, 32'h8000_0012, 32'h0, 3'd2, 32'h0000_5A22, 1'b0);

        run("sw_14", 1'b1, 32'h8000_0014, 32'h0, 3'd4, 32'h0, 1'b0);
        run("sh_16", 1'b1, 32'h8000_0016, 32'hFFFF_ABCD, 3'd2, 32'h0, 1'b0);
        run("lw_14", 1'b0, 32'h8000_0014, 32'h0, 3'd4, 32'hABCD_0000, 1'b0);

        run("lh_11", 1'b0, 32'h8000_0011, 32'h0, 3'd2, 32'h0, 1'b1);
        run("sw_00", 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 3'd4, 32'h0, 1'b0);
        run("sw_02", 1'b1, 32'h8000_0002, 32'h1234_5678, 3'd4, 32'h0, 1'b1);
        run("lw_00", 1'b0, 32'h8000_0000, 32'h0, 3'd4, 32'hCAFE_F00D, 1'b0);

        run("lw_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 3'd4, 32'h0, 1'b1);
        run("lw_above", 1'b0, 32'h8000_1000, 32'h0, 3'd4, 32'h0, 1'b1);
        run("sw_top", 1'b1, 32'h8000_0FFC, 32'h0BAD_CAFE, 3'd4, 32'h0, 1'b0);
        run("lw_top", 1'b0, 32'h8000_0FFC, 32'h0, 3'd4, 32'h0BAD_CAFE, 1'b0);
        run("len3", 1'b0, 32'h8000_0010, 32'h0, 3'd3, 32'h0, 1'b1);

        xact(1'b0, 32'h8000_0010, 32'h0, 3'd4, 5, rd, er, lat);
        check("hold_rd", rd, 32'h5A22_3344);
        check("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_hs_ready", {31'b0, req_ready}, 32'd1);

        run("sw_20", 1'b1, 32'h8000_0020, 32'h0000_0077, 3'd4, 32'h0, 1'b0);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1; req_len = 3'd4;
        check("pre_abort_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | rsp_valid;
            @(posedge clk); #1;
        end
        check("abort_no_rsp", {31'b0, seen}, 32'd0);
        run("lw_20", 1'b0, 32'h8000_0020, 32'h0, 3'd4, 32'h0000_0077, 1'b0);

        xact0("l0_sw", 1'b1, 32'h8000_0040, 32'h0000_0099, 32'h0);
        xact0("l0_lw", 1'b0, 32'h8000_0040, 32'h0, 32'h0000_0099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
